display_scan_mux: RTL and testbench

Parametrised, time-multiplexed driver for a common-anode 7-segment display of NDIGITS digits, used by the board top level to show a 32-bit (or wider/narrower) debug value. Each digit gets a fixed-length scan slot containing an anti-ghosting blank interval and a PWM brightness window. Per-digit enables, decimal points and leading-zero suppression are supported. The displayed value is snapshotted once per frame so the display never tears.

---
 rtl/display_pkg.sv | 15 +
 rtl/hexto7seg.sv | 31 +++
 rtl/display_scan_mux.sv | 138 +++++++++++++
 tb/tb_display_scan_mux.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package display_pkg;

    // Scan state within one digit slot; follows the slot counter each clock.
    typedef enum logic [1:0] {
        RST   = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2,
        OFF   = 2'd3
    } scan_state_t;

    // Active-low "everything dark" segment pattern (includes decimal point).
    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage

// File: rtl/hexto7seg.sv
// Hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module hexto7seg (
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    // Pure lookup; a 0 bit lights the corresponding segment.
    always_comb begin
        segments = 7'h7F;
        case (nibble)
            4'h0: segments = 7'h40;
            4'h1: segments = 7'h79;
            4'h2: segments = 7'h24;
            4'h3: segments = 7'h30;
            4'h4: segments = 7'h19;
            4'h5: segments = 7'h12;
            4'h6: segments = 7'h02;
            4'h7: segments = 7'h78;
            4'h8: segments = 7'h00;
            4'h9: segments = 7'h10;
            4'hA: segments = 7'h08;
            4'hB: segments = 7'h03;
            4'hC: segments = 7'h46;
            4'hD: segments = 7'h21;
            4'hE: segments = 7'h06;
            4'hF: segments = 7'h0E;
            default: segments = 7'h7F;
        endcase
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver. Each digit owns a slot of
// 2^DIV_BITS clocks: a blank interval for anti-ghosting, then a PWM window
// sized by brightness. Inputs are snapshotted once per frame so a frame
// never mixes two values. All outputs are registered and change together,
// so a new segment pattern never appears under the previous digit select.
// Handshake: none; the display free-runs and frame_start is a one-clock
// strobe in the clock after each snapshot.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int NDIGITS      = 8,
    parameter int DIV_BITS     = 17,
    parameter int BLANK_CYCLES = 64,
    parameter int BRIGHT_BITS  = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4*NDIGITS-1:0]     val,
    input  logic [NDIGITS-1:0]       dp,
    input  logic [NDIGITS-1:0]       enable_mask,
    input  logic                     lz_blank,
    input  logic [BRIGHT_BITS-1:0]   brightness,
    output logic [7:0]               segments,
    output logic [NDIGITS-1:0]       digitselect,
    output logic                     frame_start,
    output logic [1:0]               scan_state
);

    localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [DW-1:0] D_LAST = DW'(NDIGITS - 1);

    logic [DIV_BITS-1:0]    t;
    logic [DW-1:0]          d;
    logic [4*NDIGITS-1:0]   sh_val;
    logic [NDIGITS-1:0]     sh_dp;
    logic [NDIGITS-1:0]     sh_en;
    logic                   sh_lz;
    logic [BRIGHT_BITS-1:0] sh_br;

    // On the snapshot clock the shadows are being loaded; decisions for that
    // clock use the values being captured so the whole frame is consistent.
    logic                   snap;
    logic [4*NDIGITS-1:0]   cur_val;
    logic [NDIGITS-1:0]     cur_dp;
    logic [NDIGITS-1:0]     cur_en;
    logic                   cur_lz;
    logic [BRIGHT_BITS-1:0] cur_br;

    assign snap    = (t == '0) && (d == '0);
    assign cur_val = snap ? val         : sh_val;
    assign cur_dp  = snap ? dp          : sh_dp;
    assign cur_en  = snap ? enable_mask : sh_en;
    assign cur_lz  = snap ? lz_blank    : sh_lz;
    assign cur_br  = snap ? brightness  : sh_br;

    logic [NDIGITS-1:0] suppress;
    logic               lead;

    // Leading-zero priority scan from the top digit down; digit 0 always shows.
    always_comb begin
        suppress = '0;
        lead     = cur_lz;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            if (lead && (cur_val[4*i +: 4] == 4'h0) && !cur_dp[i]) begin
                suppress[i] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    logic [3:0] nibble;
    logic [6:0] hex_seg;

    assign nibble = cur_val[4*d +: 4];

    hexto7seg u_hexto7seg (
        .nibble   (nibble),
        .segments (hex_seg)
    );

    logic               in_blank;
    logic               in_window;
    scan_state_t        next_state;
    logic               lit;
    logic [NDIGITS-1:0] sel_onehot_n;

    assign in_blank     = 32'(t) < 32'(BLANK_CYCLES);
    assign in_window    = t[DIV_BITS-1 -: BRIGHT_BITS] <= cur_br;
    assign next_state   = in_blank ? BLANK : (in_window ? ON : OFF);
    assign lit          = (next_state == ON) && cur_en[d] && !suppress[d];
    assign sel_onehot_n = ~(NDIGITS'(1) << d);

    // Slot/digit counters and per-frame shadow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            t      <= '0;
            d      <= '0;
            sh_val <= '0;
            sh_dp  <= '0;
            sh_en  <= '0;
            sh_lz  <= 1'b0;
            sh_br  <= '0;
        end else begin
            t <= t + 1'b1;
            if (t == '1) begin
                d <= (d == D_LAST) ? '0 : d + 1'b1;
            end
            if (snap) begin
                sh_val <= val;
                sh_dp  <= dp;
                sh_en  <= enable_mask;
                sh_lz  <= lz_blank;
                sh_br  <= brightness;
            end
        end
    end

    scan_state_t state;

    // Scan FSM with registered outputs: state and pins reflect the previous t.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RST;
            segments    <= SEG_OFF;
            digitselect <= '1;
            frame_start <= 1'b0;
        end else begin
            state       <= next_state;
            frame_start <= snap;
            segments    <= lit ? {~cur_dp[d], hex_seg} : SEG_OFF;
            digitselect <= lit ? sel_onehot_n : '1;
        end
    end

    assign scan_state = state;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux with a 4-digit, 16-clock-slot configuration.
// The driver pushes one expected {frame_start, digitselect, segments} word
// per clock of each frame; the monitor pops and compares one per clock.
module tb_display_scan_mux;

    localparam int NDIGITS      = 4;
    localparam int DIV_BITS     = 4;
    localparam int BLANK_CYCLES = 2;
    localparam int BRIGHT_BITS  = 2;
    localparam int FRAME        = 64;
    localparam int W            = 13;

    logic                 clock;
    logic                 reset;
    logic [15:0]          val;
    logic [3:0]           dp;
    logic [3:0]           enable_mask;
    logic                 lz_blank;
    logic [1:0]           brightness;
    logic [7:0]           segments;
    logic [3:0]           digitselect;
    logic                 frame_start;
    logic [1:0]           scan_state;

    logic [W-1:0] exp_q[$];
    int           tag_q[$];
    int           n_cmp;
    int           n_bad;

    display_scan_mux #(
        .NDIGITS      (NDIGITS),
        .DIV_BITS     (DIV_BITS),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_BITS  (BRIGHT_BITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .val         (val),
        .dp          (dp),
        .enable_mask (enable_mask),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .segments    (segments),
        .digitselect (digitselect),
        .frame_start (frame_start),
        .scan_state  (scan_state)
    );

    // Clock and initial reset levels
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    localparam logic [W-1:0] RST_WORD = {1'b0, 4'hF, 8'hFF};

    // Expected output for frame position g: slot d = g/16, t = g%16.
    // Lit when the digit is expected visible, past the 2-clock blank, and
    // the slot quarter t/4 is within brightness.
    function automatic logic [W-1:0] expect_word(input int g, input logic [31:0] eseg,
                                                 input logic [3:0] eon, input logic [1:0] br);
        int         dd;
        int         tt;
        logic       lit;
        logic [7:0] seg;
        logic [3:0] sel;
        dd  = g / 16;
        tt  = g % 16;
        lit = eon[dd] && (tt >= 2) && ((tt / 4) <= int'(br));
        seg = lit ? eseg[8*dd +: 8] : 8'hFF;
        sel = lit ? ~(4'b0001 << dd) : 4'hF;
        return {(g == 0), sel, seg};
    endfunction

    // Entered one clock before a snapshot edge; leaves at the same phase of
    // the next frame (or after ncyc clocks for a cut-short frame).
    task automatic run_frame(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] en,
                             input logic lz, input logic [1:0] br,
                             input logic [31:0] eseg, input logic [3:0] eon,
                             input int ncyc, input int chg_at, input logic [15:0] chg_val);
        val         = v;
        dp          = dpv;
        enable_mask = en;
        lz_blank    = lz;
        brightness  = br;
        @(posedge clock);
        for (int g = 0; g < ncyc; g++) begin
            exp_q.push_back(expect_word(g, eseg, eon, br));
            tag_q.push_back(g);
        end
        for (int g = 1; g < ncyc; g++) begin
            @(posedge clock);
            if (g == chg_at) begin
                #1;
                val = chg_val;
            end
        end
        #1;
    endtask

    // Monitor: one expected word per clock, sampled mid-cycle.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [W-1:0] e;
            int           g;
            e = exp_q.pop_front();
            g = tag_q.pop_front();
            n_cmp++;
            if ({frame_start, digitselect, segments} !== e) begin
                n_bad++;
                $display("FAIL scan_out g=%0d got fs=%b sel=%b seg=%h exp fs=%b sel=%b seg=%h",
                         g, frame_start, digitselect, segments, e[12], e[11:8], e[7:0]);
            end
        end
    end

    // Directed stimulus
    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        reset       = 1'b1;
        val         = '0;
        dp          = '0;
        enable_mask = '0;
        lz_blank    = 1'b0;
        brightness  = '0;

        @(posedge clock);
        #1;
        repeat (3) begin
            @(posedge clock);
            exp_q.push_back(RST_WORD);
            tag_q.push_back(-1);
        end
        #1;
        reset = 1'b0;

        // Full brightness, two consecutive frames: 1234 on digits 3..0.
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 32'hF9A4B099, 4'hF, FRAME, -1, '0);
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 32'hF9A4B099, 4'hF, FRAME, -1, '0);
        // Dimmest and next level.
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd0, 32'hF9A4B099, 4'hF, FRAME, -1, '0);
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd1, 32'hF9A4B099, 4'hF, FRAME, -1, '0);
        // Leading-zero suppression, without and with a top decimal point.
        run_frame(16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 32'hFFFF92C0, 4'b0011, FRAME, -1, '0);
        run_frame(16'h0050, 4'h8, 4'hF, 1'b1, 2'd3, 32'h40C092C0, 4'hF, FRAME, -1, '0);
        // Digit 2 disabled: slot dark, frame length unchanged.
        run_frame(16'h1234, 4'h0, 4'b1011, 1'b0, 2'd3, 32'hF9A4B099, 4'b1011, FRAME, -1, '0);
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 32'hF9A4B099, 4'hF, FRAME, -1, '0);
        // Value changes during digit 1's slot; visible only next frame.
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 32'hF9A4B099, 4'hF, FRAME, 20, 16'hABCD);
        run_frame(16'hABCD, 4'h0, 4'hF, 1'b0, 2'd3, 32'h8883C6A1, 4'hF, FRAME, -1, '0);
        // Reset lands on t=7 of digit 2 (frame position 39).
        run_frame(16'hABCD, 4'h0, 4'hF, 1'b0, 2'd3, 32'h8883C6A1, 4'hF, 39, -1, '0);
        reset = 1'b1;
        repeat (2) begin
            @(posedge clock);
            exp_q.push_back(RST_WORD);
            tag_q.push_back(-1);
        end
        #1;
        reset = 1'b0;
        run_frame(16'h1234, 4'h0, 4'hF, 1'b0, 2'd3, 32'hF9A4B099, 4'hF, FRAME, -1, '0);

        // Let the monitor drain within a bounded number of clocks.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(posedge clock);
        @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending exp 0 pending", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
